// File: rtl/seq_stream_gen.sv
// seq_stream_gen: upstream stimulus stage for the sequence-detector FSMs.
// Parallel words are written through a valid/ready port into a small FIFO,
// then serialized MSB-first onto in_seq at one bit per enabled clock.
// Consecutive words are emitted with no gap bits.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset, clears all state
//   wr_valid   - write request
//   wr_data    - word to serialize
//   wr_ready   - FIFO can accept a word (level < DEPTH), combinational
//   enable     - serializer advances only while high
//   in_seq     - registered serial bit to the detector
//   bit_valid  - registered, in_seq carries a fresh bit this cycle
//   word_start - registered 1-cycle pulse, in_seq is a word's MSB
//   busy       - serializer is in SHIFT
//   level      - FIFO occupancy
//   words_sent - completed-word counter, wraps at 16 bits
module seq_stream_gen #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     enable,
  output logic                     in_seq,
  output logic                     bit_valid,
  output logic                     word_start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              in_seq_q, in_seq_d;
  logic              bit_valid_q, bit_valid_d;
  logic              word_start_q, word_start_d;
  logic [15:0]       words_sent_q, words_sent_d;

  logic              push_s;
  logic              pop_s;
  logic              fifo_ne_s;
  logic [WIDTH-1:0]  head_s;

  assign wr_ready  = (level_q < LW'(DEPTH));
  assign push_s    = wr_valid && wr_ready;
  assign fifo_ne_s = (level_q != '0);
  assign head_s    = mem_q[rd_ptr_q];

  // Serializer next-state, FIFO pop decision and pointer/level update.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    in_seq_d     = in_seq_q;
    bit_valid_d  = 1'b0;
    word_start_d = 1'b0;
    words_sent_d = words_sent_q;
    pop_s        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && fifo_ne_s) begin
          pop_s = 1'b1;
        end else begin
          in_seq_d = IDLE_BIT;
        end
      end
      S_SHIFT: begin
        if (!enable) begin
          // Stall: hold shreg/bit_cnt/in_seq, only bit_valid drops.
          state_d = S_SHIFT;
        end else if (bit_cnt_q != CW'(WIDTH)) begin
          in_seq_d    = shreg_q[WIDTH-1];
          shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = bit_cnt_q + CW'(1);
          bit_valid_d = 1'b1;
        end else begin
          // Last bit is on in_seq: the word completes on this edge and
          // the next word (if any) follows without a gap cycle.
          words_sent_d = words_sent_q + 16'd1;
          if (fifo_ne_s) begin
            pop_s = 1'b1;
          end else begin
            in_seq_d = IDLE_BIT;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        in_seq_d = IDLE_BIT;
      end
    endcase

    if (pop_s) begin
      in_seq_d     = head_s[WIDTH-1];
      shreg_d      = {head_s[WIDTH-2:0], 1'b0};
      bit_cnt_d    = CW'(1);
      bit_valid_d  = 1'b1;
      word_start_d = 1'b1;
      state_d      = S_SHIFT;
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d     = rd_ptr_q;
    end

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      in_seq_q     <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      words_sent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      in_seq_q     <= in_seq_d;
      bit_valid_q  <= bit_valid_d;
      word_start_q <= word_start_d;
      words_sent_q <= words_sent_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate access.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign in_seq     = in_seq_q;
  assign bit_valid  = bit_valid_q;
  assign word_start = word_start_q;
  assign busy       = (state_q == S_SHIFT);
  assign level      = level_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_seq_stream_gen.sv
// Self-checking bench for seq_stream_gen: directed scenarios plus a random
// run, each compared against a word-queue reference model.
module tb_seq_stream_gen;

  localparam int   W  = 8;
  localparam int   D  = 4;
  localparam logic IB = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          enable = 1'b0;
  logic          wr_ready, in_seq, bit_valid, word_start, busy;
  logic [2:0]    level;
  logic [15:0]   words_sent;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue of words, plus the word being shown.
  logic [W-1:0]  mq [$];
  logic [W-1:0]  m_cur;
  bit            m_act;
  int            m_idx;
  logic          m_in, m_valid, m_start;
  logic [15:0]   m_sent;

  seq_stream_gen #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(IB)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .enable(enable), .in_seq(in_seq),
    .bit_valid(bit_valid), .word_start(word_start), .busy(busy),
    .level(level), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit wv, input logic [W-1:0] wd, input bit en);
    int sz;
    bit acc;
    if (r) begin
      mq.delete();
      m_act = 0; m_idx = 0; m_in = IB; m_valid = 0; m_start = 0; m_sent = 16'd0;
    end else begin
      sz = mq.size();
      acc = wv && (sz < D);
      m_start = 0;
      if (en) begin
        if (m_act && m_idx < W - 1) begin
          m_idx++;
          m_in = m_cur[W-1-m_idx];
          m_valid = 1;
        end else begin
          if (m_act) m_sent = m_sent + 16'd1;
          if (sz > 0) begin
            m_cur = mq.pop_front();
            m_act = 1; m_idx = 0;
            m_in = m_cur[W-1]; m_valid = 1; m_start = 1;
          end else begin
            m_act = 0; m_in = IB; m_valid = 0;
          end
        end
      end else begin
        m_valid = 0;
        if (!m_act) m_in = IB;
      end
      if (acc) mq.push_back(wd);
    end
  endtask

  // One clock: apply inputs, take the edge, advance the model, settle.
  task automatic cyc(input bit r, input bit wv, input logic [W-1:0] wd, input bit en);
    reset = r; wr_valid = wv; wr_data = wd; enable = en;
    @(posedge clk);
    model_edge(r, wv, wd, en);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    checks++;
    if ({in_seq, bit_valid, word_start, busy, level, words_sent, wr_ready} !==
        {IB, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got in=%b v=%b ws=%b busy=%b lvl=%0d sent=%0d rdy=%b",
               in_seq, bit_valid, word_start, busy, level, words_sent, wr_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'h36;
    cyc(0, 1, w, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, '0, 1);
      checks++;
      if ({in_seq, bit_valid, word_start} !== {w[7-i], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL single_bit%0d: got in=%b v=%b ws=%b want in=%b v=1 ws=%b",
                 i, in_seq, bit_valid, word_start, w[7-i], (i == 0));
      end
    end
    cyc(0, 0, '0, 1);
    checks++;
    if ({in_seq, bit_valid, busy, words_sent} !== {1'b0, 1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL single_end: got in=%b v=%b busy=%b sent=%0d want 0 0 0 1",
               in_seq, bit_valid, busy, words_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pat;
    pat = 24'h6DB301;
    cyc(1, 0, '0, 0);
    cyc(0, 1, 8'h6D, 1);
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      cyc(0, 1, 8'hB3, 1);
      else if (i == 1) cyc(0, 1, 8'h01, 1);
      else             cyc(0, 0, '0, 1);
      checks++;
      if ({in_seq, bit_valid, word_start} !== {pat[23-i], 1'b1, (i % 8 == 0)}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got in=%b v=%b ws=%b want in=%b v=1 ws=%b",
                 i, in_seq, bit_valid, word_start, pat[23-i], (i % 8 == 0));
      end
    end
    cyc(0, 0, '0, 1);
    checks++;
    if ({words_sent, busy, bit_valid} !== {16'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_end: got sent=%0d busy=%b v=%b want 3 0 0", words_sent, busy, bit_valid);
    end
  endtask

  task automatic test_full();
    int starts;
    logic [15:0] s0;
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'(8'h11 * (i + 1)), 0);
      checks++;
      if ({level, wr_ready} !== {3'((i < 4) ? i + 1 : 4), (i < 3)}) begin
        errors++;
        $display("FAIL full_fill%0d: got lvl=%0d rdy=%b want lvl=%0d rdy=%b",
                 i, level, wr_ready, (i < 4) ? i + 1 : 4, (i < 3));
      end
    end
    s0 = words_sent;
    starts = 0;
    for (int i = 0; i < 4 * W + 2; i++) begin
      cyc(0, 0, '0, 1);
      if (word_start) starts++;
      checks++;
      if ({in_seq, bit_valid, word_start} !== {m_in, m_valid, m_start}) begin
        errors++;
        $display("FAIL full_drain%0d: got in=%b v=%b ws=%b want %b %b %b",
                 i, in_seq, bit_valid, word_start, m_in, m_valid, m_start);
      end
    end
    checks++;
    if (starts != 4 || words_sent !== s0 + 16'd4 || level !== 3'd0) begin
      errors++;
      $display("FAIL full_count: got starts=%0d sent=%0d lvl=%0d want 4 %0d 0",
               starts, words_sent, level, s0 + 16'd4);
    end
  endtask

  task automatic test_stall();
    cyc(1, 0, '0, 0);
    cyc(0, 1, 8'hF0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      checks++;
      if ({in_seq, bit_valid} !== 2'b11) begin
        errors++;
        $display("FAIL stall_pre%0d: got in=%b v=%b want 1 1", i, in_seq, bit_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 0);
      checks++;
      if ({in_seq, bit_valid, busy} !== 3'b101) begin
        errors++;
        $display("FAIL stall_hold%0d: got in=%b v=%b busy=%b want 1 0 1", i, in_seq, bit_valid, busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      checks++;
      if ({in_seq, bit_valid, word_start} !== 3'b010) begin
        errors++;
        $display("FAIL stall_post%0d: got in=%b v=%b ws=%b want 0 1 0", i, in_seq, bit_valid, word_start);
      end
    end
    cyc(0, 0, '0, 1);
    checks++;
    if ({words_sent, bit_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_end: got sent=%0d v=%b busy=%b want 1 0 0", words_sent, bit_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    cyc(1, 0, '0, 0);
    cyc(0, 1, 8'hA5, 1);
    cyc(0, 1, 8'h3C, 1);
    cyc(0, 1, 8'h81, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
    checks++;
    if ({level, busy, in_seq} !== {3'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rmid_pre: got lvl=%0d busy=%b in=%b want 2 1 1", level, busy, in_seq);
    end
    cyc(1, 0, '0, 1);
    checks++;
    if ({in_seq, bit_valid, level, words_sent, busy} !== {IB, 1'b0, 3'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_reset: got in=%b v=%b lvl=%0d sent=%0d busy=%b",
               in_seq, bit_valid, level, words_sent, busy);
    end
    w = 8'h9E;
    cyc(0, 1, w, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, '0, 1);
      checks++;
      if ({in_seq, bit_valid, word_start} !== {w[7-i], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL rmid_new%0d: got in=%b v=%b ws=%b want %b 1 %b",
                 i, in_seq, bit_valid, word_start, w[7-i], (i == 0));
      end
    end
  endtask

  task automatic test_wrap();
    cyc(1, 0, '0, 0);
    force dut.words_sent_q = 16'hFFFF;
    #1;
    release dut.words_sent_q;
    m_sent = 16'hFFFF;
    cyc(0, 1, 8'h5A, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 1);
    checks++;
    if (words_sent !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre: got sent=%h want ffff", words_sent);
    end
    cyc(0, 0, '0, 1);
    checks++;
    if (words_sent !== 16'h0000 || m_sent !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: got sent=%h want 0000", words_sent);
    end
  endtask

  task automatic test_random();
    bit r, wv, en;
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      wv = ($urandom_range(0, 2) != 0);
      en = ($urandom_range(0, 3) != 0);
      cyc(r, wv, 8'($urandom), en);
      checks++;
      if ({in_seq, bit_valid, word_start, busy, wr_ready, level, words_sent} !==
          {m_in, m_valid, m_start, m_act, (mq.size() < D), 3'(mq.size()), m_sent}) begin
        errors++;
        $display("FAIL random%0d: got in=%b v=%b ws=%b busy=%b rdy=%b lvl=%0d sent=%0d want %b %b %b %b %b %0d %0d",
                 i, in_seq, bit_valid, word_start, busy, wr_ready, level, words_sent,
                 m_in, m_valid, m_start, m_act, (mq.size() < D), mq.size(), m_sent);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stream_gen.md
Name: seq_stream_gen

Overview:
- Upstream stimulus stage for the sequence-detector FSMs.
- Accepts parallel words through a valid/ready write port and buffers them in a small FIFO.
- Serializes each word MSB-first onto a single-bit stream that drives the detector's serial input, one bit per clock.
- Back-to-back words are emitted with no gap bits, so patterns that span word boundaries stay detectable.

Parameters:
- WIDTH, 8, bits per word; 2..32.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- IDLE_BIT, 0, level driven on in_seq when no word is being shifted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wr_valid  in  1  write request.
- wr_data  in  WIDTH  word to serialize.
- wr_ready  out  1  FIFO can accept a word; high when level < DEPTH.
- enable  in  1  when low, the serializer stalls.
- in_seq  out  1  serial bit to the detector; registered.
- bit_valid  out  1  in_seq carries a fresh bit this cycle; registered.
- word_start  out  1  in_seq is bit MSB of a word; registered, 1-cycle pulse.
- busy  out  1  state is SHIFT.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- words_sent  out  16  count of completed words; wraps 0xFFFF to 0.

Behaviour:
- Reset values: in_seq=IDLE_BIT, bit_valid=0, word_start=0, busy=0, level=0, words_sent=0, wr_ready=1. The FIFO pointers clear, and state goes to IDLE.
- Reset mid-word drops the in-flight word and all buffered words. in_seq returns to IDLE_BIT on the reset edge.
- Write: a push occurs on an edge where wr_valid && wr_ready. wr_ready is combinational from level. A write while full is ignored, since wr_ready=0.
- Pop uses registered FIFO output. A word pushed at edge k is poppable at edge k+1 at the earliest.
- Push and pop on the same edge leave level unchanged.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If enable && level>0, the edge pops a word and sets in_seq<=word[WIDTH-1], shreg<=word<<1, bit_cnt<=1, bit_valid<=1, word_start<=1. State goes to SHIFT.
  - Otherwise in_seq<=IDLE_BIT and bit_valid<=0.
- SHIFT with enable=1 and bit_cnt<WIDTH: in_seq<=shreg[WIDTH-1], shreg<<=1, bit_cnt++, bit_valid<=1, word_start<=0.
- SHIFT with enable=1 and bit_cnt==WIDTH (the last bit is currently on in_seq):
  - words_sent increments.
  - If level>0, the next word is popped exactly as in IDLE, with no gap cycle.
  - If level==0, in_seq<=IDLE_BIT, bit_valid<=0, and state goes to IDLE.
- SHIFT with enable=0: state, shreg and bit_cnt are held, in_seq holds its last value, and bit_valid<=0. On resume, the next edge continues exactly where it stopped.
- IDLE with enable=0: no pop, even if level>0.
- Latency: a word pushed at edge k into an empty FIFO while IDLE with enable=1 has its MSB on in_seq after edge k+1. Its LSB is on in_seq after edge k+WIDTH.
- busy equals (state==SHIFT).
- Every bit of a word is driven for exactly one enabled cycle. No duplication or skipping occurs across stalls or word boundaries.

Test Plan:
1. Reset, then push 0x36 (WIDTH=8) with enable=1 → starting the cycle after the push, in_seq runs 0,0,1,1,0,1,1,0. word_start is high only on the first bit, bit_valid is high for 8 cycles, then in_seq=0, words_sent=1, busy=0.
2. Push 0x6D, 0xB3, 0x01 on consecutive cycles → 24 contiguous valid bits 01101101 10110011 00000001 with no gap. word_start pulses at bits 0, 8 and 16, and words_sent=3.
3. Push 5 words with enable=0 and wr_valid held high → level climbs to 4, wr_ready=0, and the 5th word is not accepted. Raising enable drains exactly 4 words.
4. Deassert enable for 3 cycles after bit 3 of 0xF0 → in_seq holds 1 with bit_valid=0 for 3 cycles. The remaining bits resume 0,0,0,0 with no lost or repeated bit.
5. Assert reset after bit 5 of a word, with 2 words buffered → on the next cycle in_seq=IDLE_BIT, level=0, words_sent=0, busy=0. A new push after reset serializes from its MSB.
6. Run 65536 single-word transfers, or force the counter to 0xFFFF → words_sent wraps to 0 on the next completed word.
